// File: rtl/uart_channel_arbiter.sv
// UART channel ownership arbiter in front of the SPI bootloader.
// The first UART channel to deliver a byte owns the bootloader until it stays
// idle for TIMEOUT_CYCLES or a break is seen. Replies go only to the owner and
// the other channel's bytes are dropped. Breaks from either channel become a
// registered bootloader reset.
// Optional build macro UART_ARB_STATS_EN adds the drop_count output.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no owner; first byte claims the bootloader, replies broadcast
// ST_LOCKED | owner_q owns the bootloader; non-owner bytes are discarded
module uart_channel_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ch0_rx_valid,
    input  logic [7:0] ch0_rx_data,
    output logic       ch0_rx_ready,
    input  logic       ch0_rx_break,
    output logic       ch0_tx_valid,
    output logic [7:0] ch0_tx_data,
    input  logic       ch0_tx_ready,
    input  logic       ch1_rx_valid,
    input  logic [7:0] ch1_rx_data,
    output logic       ch1_rx_ready,
    input  logic       ch1_rx_break,
    output logic       ch1_tx_valid,
    output logic [7:0] ch1_tx_data,
    input  logic       ch1_tx_ready,
    output logic       bl_in_valid,
    output logic [7:0] bl_in_data,
    input  logic       bl_in_ready,
    input  logic       bl_out_valid,
    input  logic [7:0] bl_out_data,
    output logic       bl_out_ready,
    output logic       bl_reset,
    output logic       locked,
`ifdef UART_ARB_STATS_EN
    output logic [7:0] drop_count,
`endif
    output logic       owner
);

    // Width of 1 when the timeout is disabled so the (unused) timer stays legal.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMER_LOAD =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [0:0] {ST_IDLE, ST_LOCKED} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             buf_valid_q, buf_valid_d;
    logic [7:0]       buf_data_q, buf_data_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             bl_reset_q, bl_reset_d;

    logic       brk;
    logic       free;
    logic       is_locked;
    logic       sel_ch1;
    logic       acc_xfer;
    logic [7:0] acc_data;
    logic       drop;
    logic       bcast;
    logic       bl_out_xfer;

    // Ready generation, channel selection and reply routing.
    always_comb begin
        brk       = ch0_rx_break | ch1_rx_break;
        free      = !buf_valid_q | bl_in_ready;
        is_locked = (state_q == ST_LOCKED);
        sel_ch1   = is_locked ? owner_q : (!ch0_rx_valid & ch1_rx_valid);

        ch0_rx_ready = 1'b0;
        ch1_rx_ready = 1'b0;
        if (!brk) begin
            if (is_locked) begin
                ch0_rx_ready = owner_q ? 1'b1 : free;
                ch1_rx_ready = owner_q ? free : 1'b1;
            end else begin
                ch0_rx_ready = free & !sel_ch1;
                ch1_rx_ready = free & sel_ch1;
            end
        end

        acc_xfer = sel_ch1 ? (ch1_rx_valid & ch1_rx_ready) : (ch0_rx_valid & ch0_rx_ready);
        acc_data = sel_ch1 ? ch1_rx_data : ch0_rx_data;
        drop     = is_locked & !brk & (owner_q ? ch0_rx_valid : ch1_rx_valid);

        // Broadcast only when both transmitters can take the byte together.
        bcast = bl_out_valid & ch0_tx_ready & ch1_tx_ready;
        if (is_locked) begin
            ch0_tx_valid = bl_out_valid & !owner_q;
            ch1_tx_valid = bl_out_valid & owner_q;
            bl_out_ready = owner_q ? ch1_tx_ready : ch0_tx_ready;
        end else begin
            ch0_tx_valid = bcast;
            ch1_tx_valid = bcast;
            bl_out_ready = bcast;
        end
        ch0_tx_data = bl_out_data;
        ch1_tx_data = bl_out_data;
        bl_out_xfer = bl_out_valid & bl_out_ready;
    end

    // Next-state: ownership, input buffer, idle timer and break handling.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        buf_valid_d = buf_valid_q & !bl_in_ready;
        buf_data_d  = buf_data_q;
        timer_d     = timer_q;
        bl_reset_d  = brk;
        if (brk) begin
            state_d     = ST_IDLE;
            buf_valid_d = 1'b0;
            timer_d     = '0;
        end else begin
            if (acc_xfer) begin
                buf_valid_d = 1'b1;
                buf_data_d  = acc_data;
            end
            if (!is_locked) begin
                if (acc_xfer) begin
                    state_d = ST_LOCKED;
                    owner_d = sel_ch1;
                    timer_d = TIMER_LOAD;
                end
            end else if (acc_xfer || bl_out_xfer) begin
                timer_d = TIMER_LOAD;
            end else if (TIMEOUT_CYCLES != 0) begin
                // Timeout releases ownership; a buffered byte is still delivered.
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= 8'h00;
            timer_q     <= '0;
            bl_reset_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            timer_q     <= timer_d;
            bl_reset_q  <= bl_reset_d;
        end
    end

    assign bl_in_valid = buf_valid_q;
    assign bl_in_data  = buf_data_q;
    assign bl_reset    = bl_reset_q;
    assign locked      = (state_q == ST_LOCKED);
    assign owner       = owner_q;

`ifdef UART_ARB_STATS_EN
    logic [7:0] drop_count_q, drop_count_d;

    // Saturating count of discarded non-owner bytes, cleared by break.
    always_comb begin
        drop_count_d = drop_count_q;
        if (brk) begin
            drop_count_d = 8'h00;
        end else if (drop && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'h01;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= 8'h00;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_channel_arbiter.sv
// Scoreboard bench for uart_channel_arbiter (TIMEOUT_CYCLES = 16).
module tb_uart_channel_arbiter;

    logic       clk;
    logic       reset;
    logic       ch0_rx_valid, ch0_rx_ready, ch0_rx_break, ch0_tx_valid, ch0_tx_ready;
    logic [7:0] ch0_rx_data, ch0_tx_data;
    logic       ch1_rx_valid, ch1_rx_ready, ch1_rx_break, ch1_tx_valid, ch1_tx_ready;
    logic [7:0] ch1_rx_data, ch1_tx_data;
    logic       bl_in_valid, bl_in_ready, bl_out_valid, bl_out_ready, bl_reset;
    logic [7:0] bl_in_data, bl_out_data;
    logic       locked, owner;
`ifdef UART_ARB_STATS_EN
    logic [7:0] drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_bl[$];
    logic [7:0] exp_tx0[$];
    logic [7:0] exp_tx1[$];

    uart_channel_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .ch0_rx_valid (ch0_rx_valid),
        .ch0_rx_data  (ch0_rx_data),
        .ch0_rx_ready (ch0_rx_ready),
        .ch0_rx_break (ch0_rx_break),
        .ch0_tx_valid (ch0_tx_valid),
        .ch0_tx_data  (ch0_tx_data),
        .ch0_tx_ready (ch0_tx_ready),
        .ch1_rx_valid (ch1_rx_valid),
        .ch1_rx_data  (ch1_rx_data),
        .ch1_rx_ready (ch1_rx_ready),
        .ch1_rx_break (ch1_rx_break),
        .ch1_tx_valid (ch1_tx_valid),
        .ch1_tx_data  (ch1_tx_data),
        .ch1_tx_ready (ch1_tx_ready),
        .bl_in_valid  (bl_in_valid),
        .bl_in_data   (bl_in_data),
        .bl_in_ready  (bl_in_ready),
        .bl_out_valid (bl_out_valid),
        .bl_out_data  (bl_out_data),
        .bl_out_ready (bl_out_ready),
        .bl_reset     (bl_reset),
        .locked       (locked),
`ifdef UART_ARB_STATS_EN
        .drop_count   (drop_count),
`endif
        .owner        (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (bl_in_valid && bl_in_ready) begin
                if (exp_bl.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL bl_in_unexpected actual=%0h required=none", bl_in_data);
                end else check("bl_in_data", bl_in_data, exp_bl.pop_front());
            end
            if (ch0_tx_valid && ch0_tx_ready) begin
                if (exp_tx0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx0_unexpected actual=%0h required=none", ch0_tx_data);
                end else check("ch0_tx_data", ch0_tx_data, exp_tx0.pop_front());
            end
            if (ch1_tx_valid && ch1_tx_ready) begin
                if (exp_tx1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx1_unexpected actual=%0h required=none", ch1_tx_data);
                end else check("ch1_tx_data", ch1_tx_data, exp_tx1.pop_front());
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic pulse_break();
        ch0_rx_break = 1'b1;
        tick();
        check("brk_bl_reset_hi", bl_reset, 1);
        check("brk_unlocked", locked, 0);
        ch0_rx_break = 1'b0;
        tick();
        check("brk_bl_reset_lo", bl_reset, 0);
    endtask

    initial begin
        reset = 1'b1;
        ch0_rx_valid = 0; ch0_rx_data = 0; ch0_rx_break = 0; ch0_tx_ready = 0;
        ch1_rx_valid = 0; ch1_rx_data = 0; ch1_rx_break = 0; ch1_tx_ready = 0;
        bl_in_ready = 0; bl_out_valid = 0; bl_out_data = 0;
        tick(); tick();
        check("rst_locked", locked, 0);
        check("rst_owner", owner, 0);
        check("rst_bl_in_valid", bl_in_valid, 0);
        check("rst_bl_in_data", bl_in_data, 0);
        check("rst_bl_reset", bl_reset, 0);
        reset = 1'b0;
        tick();

        // ch0 back-to-back 0x7E, 0x01
        bl_in_ready = 1;
        ch0_rx_valid = 1; ch0_rx_data = 8'h7E; exp_bl.push_back(8'h7E);
        #1;
        check("t1_ch0_ready", ch0_rx_ready, 1);
        check("t1_bl_in_valid_pre", bl_in_valid, 0);
        tick();
        check("t1_bl_in_valid", bl_in_valid, 1);
        check("t1_bl_in_data", bl_in_data, 8'h7E);
        ch0_rx_data = 8'h01; exp_bl.push_back(8'h01);
        tick();
        ch0_rx_valid = 0;
        check("t1_bl_in_data2", bl_in_data, 8'h01);
        check("t1_locked", locked, 1);
        check("t1_owner", owner, 0);
        tick();
        pulse_break();

        // Simultaneous 0xAA / 0x55 in IDLE
        ch0_rx_valid = 1; ch0_rx_data = 8'hAA; exp_bl.push_back(8'hAA);
        ch1_rx_valid = 1; ch1_rx_data = 8'h55;
        #1;
        check("t2_ch0_ready", ch0_rx_ready, 1);
        check("t2_ch1_ready", ch1_rx_ready, 0);
        tick();
        ch0_rx_valid = 0;
        #1;
        check("t2_ch1_discard_ready", ch1_rx_ready, 1);
        check("t2_owner", owner, 0);
        check("t2_locked", locked, 1);
        tick();
        ch1_rx_valid = 0;
`ifdef UART_ARB_STATS_EN
        check("t2_drop_count", drop_count, 1);
`endif
        tick();
        pulse_break();
`ifdef UART_ARB_STATS_EN
        check("t2_drop_cleared", drop_count, 0);
`endif

        // Lock to ch1, reply 0x42 routed only to ch1
        ch1_rx_valid = 1; ch1_rx_data = 8'h10; exp_bl.push_back(8'h10);
        tick();
        ch1_rx_valid = 0;
        check("t3_owner", owner, 1);
        bl_out_valid = 1; bl_out_data = 8'h42; ch1_tx_ready = 1; ch0_tx_ready = 0;
        exp_tx1.push_back(8'h42);
        #1;
        check("t3_ch1_tx_valid", ch1_tx_valid, 1);
        check("t3_ch1_tx_data", ch1_tx_data, 8'h42);
        check("t3_ch0_tx_valid", ch0_tx_valid, 0);
        check("t3_bl_out_ready", bl_out_ready, 1);
        tick();
        bl_out_valid = 0;
        pulse_break();

        // IDLE broadcast waits for both transmitters
        bl_out_valid = 1; bl_out_data = 8'h99; ch0_tx_ready = 0; ch1_tx_ready = 1;
        #1;
        check("t3b_ch0_tx_valid", ch0_tx_valid, 0);
        check("t3b_ch1_tx_valid", ch1_tx_valid, 0);
        check("t3b_bl_out_ready", bl_out_ready, 0);
        tick();
        ch0_tx_ready = 1;
        exp_tx0.push_back(8'h99); exp_tx1.push_back(8'h99);
        #1;
        check("t3b_bcast_ready", bl_out_ready, 1);
        check("t3b_bcast_tx0", ch0_tx_valid, 1);
        tick();
        bl_out_valid = 0;

        // Timeout: ch0 locks then stays silent for 16 cycles
        ch0_rx_valid = 1; ch0_rx_data = 8'h33; exp_bl.push_back(8'h33);
        tick();
        ch0_rx_valid = 0;
        check("t4_locked_start", locked, 1);
        repeat (15) tick();
        check("t4_locked_15", locked, 1);
        tick();
        check("t4_released_16", locked, 0);
        ch1_rx_valid = 1; ch1_rx_data = 8'h44; exp_bl.push_back(8'h44);
        #1;
        check("t4_ch1_ready", ch1_rx_ready, 1);
        tick();
        ch1_rx_valid = 0;
        check("t4_relock", locked, 1);
        check("t4_owner1", owner, 1);
        tick();

        // Full buffer, then break held 3 cycles
        bl_in_ready = 0;
        ch1_rx_valid = 1; ch1_rx_data = 8'h55;
        tick();
        ch1_rx_valid = 0;
        check("t5_buf_full", bl_in_valid, 1);
        ch1_rx_break = 1;
        ch0_rx_valid = 1; ch0_rx_data = 8'h77;
        #1;
        check("t5_no_accept_brk", ch0_rx_ready, 0);
        check("t5_bl_reset_latency", bl_reset, 0);
        tick();
        check("t5_bl_reset_c1", bl_reset, 1);
        check("t5_flushed", bl_in_valid, 0);
        check("t5_unlocked", locked, 0);
        tick();
        check("t5_bl_reset_c2", bl_reset, 1);
        tick();
        check("t5_bl_reset_c3", bl_reset, 1);
        ch1_rx_break = 0; ch0_rx_valid = 0; bl_in_ready = 1;
        tick();
        check("t5_bl_reset_end", bl_reset, 0);

        // Asynchronous reset mid-transfer
        bl_in_ready = 0;
        ch1_rx_valid = 1; ch1_rx_data = 8'h66;
        tick();
        ch1_rx_valid = 0;
        check("t6_pre_locked", locked, 1);
        check("t6_pre_valid", bl_in_valid, 1);
        #2;
        reset = 1;
        #1;
        check("t6_locked", locked, 0);
        check("t6_owner", owner, 0);
        check("t6_bl_in_valid", bl_in_valid, 0);
        check("t6_bl_in_data", bl_in_data, 0);
        check("t6_bl_reset", bl_reset, 0);
        tick();
        reset = 0;
        bl_in_ready = 1;
        tick(); tick();

        check("q_bl_empty", exp_bl.size(), 0);
        check("q_tx0_empty", exp_tx0.size(), 0);
        check("q_tx1_empty", exp_tx1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
